vx_cache_bank_sched: RTL and testbench
======================================

// Module: vx_cache_bank_sched
// PURPOSE
// - Per-bank request scheduler in front of the bank pipeline st0: picks one of {init sweep, memory fill, MSHR replay, core request} per cycle.
// - Gates core requests on MSHR free-slot availability; enforces fill->replay ordering so the first replay issues while the fill is in st1.
// - Issues an init/flush sweep over all lines after reset. Output is one registered st0 slot (1-cycle latency).
// PARAMETERS
// - NUM_LINES     64  lines per bank to sweep during init; power of 2, >=2
// - MSHR_SIZE     4   MSHR entries; sizes the id fields
// - CORE_STARVE   4   max consecutive fill/replay grants while a core request waits; 0 disables anti-starvation
// - MSHR_ADDR_W   `LOG2UP(MSHR_SIZE)
// PORTS
// - clk            in   1            clock
// - reset          in   1            synchronous, active-high
// - core_valid     in   1            core request pending
// - core_ready     out  1            core request accepted this cycle
// - fill_valid     in   1            memory fill response pending
// - fill_id        in   MSHR_ADDR_W  MSHR id of fill
// - fill_ready     out  1            fill accepted this cycle
// - replay_valid   in   1            MSHR dequeue pending
// - replay_id      in   MSHR_ADDR_W  MSHR id of dequeue
// - replay_ready   out  1            dequeue accepted (drives MSHR dequeue_ready)
// - mshr_alloc_rdy in   1            MSHR has a free slot
// - pipe_stall     in   1            st0 cannot advance
// - st0_valid      out  1            st0 slot holds a request
// - st0_kind       out  2            0=core 1=fill 2=replay 3=init
// - st0_id         out  MSHR_ADDR_W  MSHR id (fill/replay), else 0
// - st0_line       out  `LOG2UP(NUM_LINES)  line index (init), else 0
// - init_done      out  1            sweep finished
// BEHAVIOUR
// - Reset: st0_valid=0, st0_kind=0, st0_id=0, st0_line=0, init_done=0, all *_ready=0, FSM=INIT, line_cnt=0, starve_cnt=0, fill_in_st0=0.
// - FSM INIT: each cycle with ~pipe_stall issues kind=3, st0_line=line_cnt, line_cnt++; no other grant. At line_cnt==NUM_LINES-1 issued -> RUN, init_done=1 next cycle.
// - FSM RUN: at most one grant per cycle, only when ~pipe_stall. Priority: fill > replay > core.
// - Core eligible only if core_valid && mshr_alloc_rdy. Replay eligible only if replay_valid && ~fill_in_st0 (fill granted previous cycle must reach st1 first).
// - Anti-starvation: starve_cnt++ on each fill/replay grant while core_valid; reset to 0 on core grant or ~core_valid. When starve_cnt==CORE_STARVE and core eligible, core wins over fill/replay (one grant), then counter clears.
// - *_ready are combinational grants; accept = valid && ready in the same cycle. Requesters must hold valid/ids until accepted.
// - st0 regs: on ~pipe_stall load grant (st0_valid=|grant, kind/id/line of winner; 0 fields when no grant). On pipe_stall hold all st0 regs, all ready=0.
// - fill_in_st0 <= fill grant && ~pipe_stall; held during pipe_stall.
// - Reset mid-operation: any cycle with reset returns to INIT and restarts the sweep from line 0; in-flight st0 slot dropped.
// - Simultaneous fill+replay+core with mshr_alloc_rdy=0: fill granted, core never granted while mshr_alloc_rdy=0 regardless of starve_cnt.
// CONFIGURATION
// - VX_CACHE_SCHED_PERF_EN defined: adds outputs perf_core_stalls (32b, cycles core_valid && ~core_ready in RUN), perf_mshr_full (32b, cycles core_valid && ~mshr_alloc_rdy); both reset to 0, wrap at 2^32.
// - Undefined: counters and ports absent; behaviour otherwise identical.
// TESTING
// - Reset release, NUM_LINES=64, no stalls -> st0_kind=3 lines 0..63 on consecutive cycles; init_done=1 the cycle after line 63; no ready asserted during INIT.
// - RUN, fill(id=2)+replay(id=1) valid same cycle -> cycle N fill_ready; cycle N+1 replay blocked (fill_in_st0); cycle N+2 replay_ready, st0_id=1.
// - core_valid, mshr_alloc_rdy=0 for 10 cycles -> core_ready=0 all 10; mshr_alloc_rdy=1 -> core_ready same cycle, st0_kind=0 next cycle.
// - CORE_STARVE=4, fill/replay always valid, core eligible -> 4 fill/replay grants then 1 core grant, pattern repeats.
// - pipe_stall asserted 3 cycles with st0 holding replay id=3 -> st0 regs unchanged, all ready=0; after release next winner loaded.
// - Reset asserted mid-sweep at line 20 -> st0_valid=0, init_done=0, sweep restarts at line 0.

Source files
------------

// File: rtl/vx_cache_bank_sched_if.sv
// Bank scheduler bus: core/fill/replay handshakes,
// MSHR status, pipe stall and the registered st0 slot.
interface vx_cache_bank_sched_if #(
  parameter int MSHR_ADDR_W = 2,
  parameter int LINE_W      = 6
);
  logic                   core_valid;
  logic                   core_ready;
  logic                   fill_valid;
  logic [MSHR_ADDR_W-1:0] fill_id;
  logic                   fill_ready;
  logic                   replay_valid;
  logic [MSHR_ADDR_W-1:0] replay_id;
  logic                   replay_ready;
  logic                   mshr_alloc_rdy;
  logic                   pipe_stall;
  logic                   st0_valid;
  logic [1:0]             st0_kind;
  logic [MSHR_ADDR_W-1:0] st0_id;
  logic [LINE_W-1:0]      st0_line;
  logic                   init_done;

  modport master (
    output core_valid,
    output fill_valid,
    output fill_id,
    output replay_valid,
    output replay_id,
    output mshr_alloc_rdy,
    output pipe_stall,
    input  core_ready,
    input  fill_ready,
    input  replay_ready,
    input  st0_valid,
    input  st0_kind,
    input  st0_id,
    input  st0_line,
    input  init_done
  );

  modport slave (
    input  core_valid,
    input  fill_valid,
    input  fill_id,
    input  replay_valid,
    input  replay_id,
    input  mshr_alloc_rdy,
    input  pipe_stall,
    output core_ready,
    output fill_ready,
    output replay_ready,
    output st0_valid,
    output st0_kind,
    output st0_id,
    output st0_line,
    output init_done
  );
endinterface

// File: rtl/vx_cache_bank_sched.sv
// Per-bank st0 scheduler: init sweep, fill > replay > core.
// Define VX_CACHE_SCHED_PERF_EN for perf counter outputs.
module vx_cache_bank_sched #(
  parameter int NUM_LINES   = 64,
  parameter int MSHR_SIZE   = 4,
  parameter int CORE_STARVE = 4,
  localparam int MSHR_ADDR_W =
    (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1,
  localparam int LINE_W =
    (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input logic clk,
  input logic reset,
  vx_cache_bank_sched_if.slave bus
`ifdef VX_CACHE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_core_stalls,
  output logic [31:0] perf_mshr_full
`endif
);

  localparam int SC_W =
    (CORE_STARVE > 0) ? $clog2(CORE_STARVE + 1) : 1;
  localparam logic [SC_W-1:0] SC_MAX =
    SC_W'(CORE_STARVE);
  localparam logic [LINE_W-1:0] LAST_LINE =
    LINE_W'(NUM_LINES - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [LINE_W-1:0]      line_cnt_q, line_cnt_d;
  logic [SC_W-1:0]        starve_q, starve_d;
  logic                   fill_st0_q, fill_st0_d;
  logic                   done_q, done_d;
  logic                   st0_vld_q, st0_vld_d;
  logic [1:0]             st0_kind_q, st0_kind_d;
  logic [MSHR_ADDR_W-1:0] st0_id_q, st0_id_d;
  logic [LINE_W-1:0]      st0_line_q, st0_line_d;

  logic advance;
  logic fill_elig;
  logic replay_elig;
  logic core_elig;
  logic core_win;
  logic fill_win;
  logic replay_win;
  logic core_lo;
  logic gnt_init;
  logic gnt_fill;
  logic gnt_replay;
  logic gnt_core;

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    starve_d    = starve_q;
    fill_st0_d  = fill_st0_q;
    done_d      = done_q;
    st0_vld_d   = st0_vld_q;
    st0_kind_d  = st0_kind_q;
    st0_id_d    = st0_id_q;
    st0_line_d  = st0_line_q;
    gnt_init    = 1'b0;
    gnt_fill    = 1'b0;
    gnt_replay  = 1'b0;
    gnt_core    = 1'b0;

    advance     = ~bus.pipe_stall & ~reset;
    fill_elig   = bus.fill_valid;
    // the fill just issued must clear st0 before a replay follows it
    replay_elig = bus.replay_valid & ~fill_st0_q;
    core_elig   = bus.core_valid & bus.mshr_alloc_rdy;
    core_win    = (CORE_STARVE != 0)
                & (starve_q == SC_MAX) & core_elig;
    fill_win    = fill_elig & ~core_win;
    replay_win  = replay_elig & ~fill_elig & ~core_win;
    core_lo     = core_elig & ~fill_elig
                & ~replay_elig & ~core_win;

    unique case (state_q)
      S_INIT: begin
        if (advance) begin
          gnt_init   = 1'b1;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == LAST_LINE) begin
            state_d    = S_RUN;
            done_d     = 1'b1;
            line_cnt_d = '0;
          end
        end
      end
      S_RUN: begin
        if (advance) begin
          unique case (1'b1)
            core_win:   gnt_core   = 1'b1;
            fill_win:   gnt_fill   = 1'b1;
            replay_win: gnt_replay = 1'b1;
            core_lo:    gnt_core   = 1'b1;
            default:    ;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase

    if (!bus.core_valid || gnt_core) begin
      starve_d = '0;
    end else if ((gnt_fill || gnt_replay)
                 && starve_q != SC_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    if (advance) begin
      fill_st0_d = gnt_fill;
      st0_vld_d  = gnt_init | gnt_fill
                 | gnt_replay | gnt_core;
      st0_kind_d = gnt_init   ? 2'd3 :
                   gnt_replay ? 2'd2 :
                   gnt_fill   ? 2'd1 : 2'd0;
      st0_id_d   = gnt_fill   ? bus.fill_id :
                   gnt_replay ? bus.replay_id : '0;
      st0_line_d = gnt_init ? line_cnt_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      line_cnt_q <= '0;
      starve_q   <= '0;
      fill_st0_q <= 1'b0;
      done_q     <= 1'b0;
      st0_vld_q  <= 1'b0;
      st0_kind_q <= '0;
      st0_id_q   <= '0;
      st0_line_q <= '0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      starve_q   <= starve_d;
      fill_st0_q <= fill_st0_d;
      done_q     <= done_d;
      st0_vld_q  <= st0_vld_d;
      st0_kind_q <= st0_kind_d;
      st0_id_q   <= st0_id_d;
      st0_line_q <= st0_line_d;
    end
  end

  assign bus.core_ready   = gnt_core;
  assign bus.fill_ready   = gnt_fill;
  assign bus.replay_ready = gnt_replay;
  assign bus.st0_valid    = st0_vld_q;
  assign bus.st0_kind     = st0_kind_q;
  assign bus.st0_id       = st0_id_q;
  assign bus.st0_line     = st0_line_q;
  assign bus.init_done    = done_q;

`ifdef VX_CACHE_SCHED_PERF_EN
  logic [31:0] pcs_q, pcs_d;
  logic [31:0] pmf_q, pmf_d;

  always_comb begin
    pcs_d = pcs_q;
    pmf_d = pmf_q;
    if (state_q == S_RUN && bus.core_valid && !gnt_core)
      pcs_d = pcs_q + 32'd1;
    if (bus.core_valid && !bus.mshr_alloc_rdy)
      pmf_d = pmf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcs_q <= '0;
      pmf_q <= '0;
    end else begin
      pcs_q <= pcs_d;
      pmf_q <= pmf_d;
    end
  end

  assign perf_core_stalls = pcs_q;
  assign perf_mshr_full   = pmf_q;
`endif

endmodule

// File: tb/tb_vx_cache_bank_sched.sv
// Directed bench for vx_cache_bank_sched: sweep, ordering,
// MSHR gating, anti-starvation, stall hold, mid-sweep reset.
module tb_vx_cache_bank_sched;
  localparam int NL  = 64;
  localparam int MS  = 4;
  localparam int CS  = 4;
  localparam int MAW = 2;
  localparam int LW  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_cache_bank_sched_if #(
    .MSHR_ADDR_W(MAW),
    .LINE_W(LW)
  ) bif ();

`ifdef VX_CACHE_SCHED_PERF_EN
  logic [31:0] pcs;
  logic [31:0] pmf;
`endif

  vx_cache_bank_sched #(
    .NUM_LINES(NL),
    .MSHR_SIZE(MS),
    .CORE_STARVE(CS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
`ifdef VX_CACHE_SCHED_PERF_EN
    ,
    .perf_core_stalls(pcs),
    .perf_mshr_full(pmf)
`endif
  );

  typedef struct packed {
    logic           v;
    logic [1:0]     k;
    logic [MAW-1:0] id;
    logic [LW-1:0]  ln;
  } st0_t;

  st0_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_done;

  function automatic st0_t s(input logic v,
                             input logic [1:0] k,
                             input logic [MAW-1:0] id,
                             input int ln);
    st0_t r;
    r.v  = v;
    r.k  = k;
    r.id = id;
    r.ln = LW'(ln);
    return r;
  endfunction

  task automatic chk(input logic [31:0] obs,
                     input logic [31:0] exp,
                     input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cv,
                       input logic ma,
                       input logic fv,
                       input logic [MAW-1:0] fid,
                       input logic rv,
                       input logic [MAW-1:0] rid,
                       input logic ps);
    bif.core_valid     = cv;
    bif.mshr_alloc_rdy = ma;
    bif.fill_valid     = fv;
    bif.fill_id        = fid;
    bif.replay_valid   = rv;
    bif.replay_id      = rid;
    bif.pipe_stall     = ps;
  endtask

  // readies checked mid-cycle; expected st0 queued, popped after edge
  task automatic tick(input logic cr,
                      input logic fr,
                      input logic rr,
                      input st0_t e,
                      input string tag);
    st0_t o;
    @(negedge clk);
    chk(32'(bif.core_ready), 32'(cr), {tag, ".core_rdy"});
    chk(32'(bif.fill_ready), 32'(fr), {tag, ".fill_rdy"});
    chk(32'(bif.replay_ready), 32'(rr), {tag, ".rep_rdy"});
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk(32'(bif.st0_valid), 32'(o.v), {tag, ".valid"});
    chk(32'(bif.st0_kind), 32'(o.k), {tag, ".kind"});
    chk(32'(bif.st0_id), 32'(o.id), {tag, ".id"});
    chk(32'(bif.st0_line), 32'(o.ln), {tag, ".line"});
    chk(32'(bif.init_done), 32'(exp_done), {tag, ".done"});
  endtask

  st0_t idle;
  st0_t core_g;

  initial begin
    idle   = s(0, 0, 0, 0);
    core_g = s(1, 0, 0, 0);
    exp_done = 1'b0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "rst_a");
    tick(0, 0, 0, idle, "rst_b");

    // requesters pending during the sweep must stay blocked
    drive(1, 1, 1, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (i == NL - 1) exp_done = 1'b1;
      tick(0, 0, 0, s(1, 3, 0, i), "init");
    end
    tick(0, 1, 0, s(1, 1, 0, 0), "run0");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "idle0");

    drive(0, 0, 1, 2, 1, 1, 0);
    tick(0, 1, 0, s(1, 1, 2, 0), "fr_fill");
    drive(0, 0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, idle, "fr_block");
    tick(0, 0, 1, s(1, 2, 1, 0), "fr_replay");

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (10) tick(0, 0, 0, idle, "mshr_full");
    drive(1, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, core_g, "mshr_ok");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "idle1");

    drive(1, 1, 1, 1, 1, 3, 0);
    repeat (4) tick(0, 1, 0, s(1, 1, 1, 0), "stv_fill");
    tick(1, 0, 0, core_g, "stv_core1");
    drive(1, 1, 0, 0, 1, 3, 0);
    repeat (4) tick(0, 0, 1, s(1, 2, 3, 0), "stv_rep");
    tick(1, 0, 0, core_g, "stv_core2");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "idle2");

    drive(1, 0, 1, 2, 1, 1, 0);
    repeat (6) tick(0, 1, 0, s(1, 1, 2, 0), "sat_fill");
    drive(1, 1, 1, 2, 1, 1, 0);
    tick(1, 0, 0, core_g, "sat_core");
    tick(0, 1, 0, s(1, 1, 2, 0), "sat_after");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "idle3");

    drive(0, 0, 0, 0, 1, 3, 0);
    tick(0, 0, 1, s(1, 2, 3, 0), "stall_load");
    drive(1, 1, 1, 2, 0, 0, 1);
    repeat (3) tick(0, 0, 0, s(1, 2, 3, 0), "stall_hold");
    drive(1, 1, 1, 2, 0, 0, 0);
    tick(0, 1, 0, s(1, 1, 2, 0), "stall_rel");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, idle, "idle4");

    reset = 1'b1;
    exp_done = 1'b0;
    tick(0, 0, 0, idle, "rst2");
    reset = 1'b0;
    for (int i = 0; i <= 20; i++)
      tick(0, 0, 0, s(1, 3, 0, i), "sweep2");
    reset = 1'b1;
    tick(0, 0, 0, idle, "rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      tick(0, 0, 0, s(1, 3, 0, i), "sweep3");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
